farm_request_conditioner: RTL and testbench
===========================================

Name: farm_request_conditioner

Overview:
Upstream stage of the farm/highway traffic light controller; produces its car-present input `c`. Synchronises and debounces the raw farm-road loop-detector signal and latches a service request. Holds the request through a bounded farm-green window, using the controller's `light_farm` output as feedback. Forces `c` low after a maximum green so the highway cannot be starved.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles before the debounced level changes (>=1)
MIN_GREEN, 8, minimum cycles `c` stays high once farm green is observed (>=1)
MAX_GREEN, 32, maximum cycles `c` stays high once farm green is observed (>=MIN_GREEN)
CNT_W, 8, width of the vehicle arrival counter

Ports:
clk  input  1  single system clock, all logic on posedge
rst_n  input  1  synchronous, active-low reset
sensor_raw  input  1  asynchronous loop-detector level, 1 = vehicle present
light_farm  input  3  controller farm lamp feedback, one-hot: red=100, yellow=010, green=001
c  output  1  registered service request to the controller
det  output  1  debounced vehicle-present level
car_count  output  CNT_W  count of debounced 0->1 arrivals, saturating at all-ones
timeout_pulse  output  1  one-cycle pulse when a farm green is cut by MAX_GREEN

Behaviour:
- Reset (rst_n=0 at a clk edge): sync flops=0, det=0, debounce count=0, car_count=0, c=0, timeout_pulse=0, green_cnt=0, state=IDLE. Reset mid-serve drops `c` on that same edge.
- Synchroniser: two flops on sensor_raw; the output is s_sync.
- Debounce:
  - The counter increments each cycle that s_sync != det.
  - The counter clears on any cycle where s_sync == det.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, det toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach det.
- Latency: a clean sensor_raw step reaches det after 2+DEBOUNCE_CYCLES edges. It reaches c one edge later, i.e. 7 edges with defaults.
- car_count increments on the edge where det goes 0->1. It holds at 2^CNT_W-1.
- light_farm decode: green = (light_farm==001), red = (light_farm==100). Any other value, including illegal ones, is neither.
- FSM (registered; c=1 exactly in REQUEST and SERVE):
  - IDLE: if det=1, go to REQUEST.
  - REQUEST: the request is latched, so det dropping does not withdraw it. If green, go to SERVE with green_cnt=0.
  - SERVE: green_cnt increments each cycle. Checks are evaluated in this order:
    1. If not green (controller left green on its own), go to RELEASE.
    2. Else if green_cnt==MAX_GREEN-1, go to RELEASE and assert timeout_pulse for one cycle.
    3. Else if green_cnt>=MIN_GREEN-1 and det=0, go to RELEASE.
  - RELEASE: c=0. If red, go to IDLE. A waiting vehicle re-requests from IDLE on the following edge.
- If MAX and MIN expiry coincide, the timeout takes priority and timeout_pulse fires.
- green_cnt is sized to clog2(MAX_GREEN)+1 bits and never wraps.
- Outputs are glitch-free registers. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package traffic_pkg:
  - light encodings RED/YELLOW/GREEN (3-bit);
  - conditioner state enum IDLE/REQUEST/SERVE/RELEASE.
  - The controller uses the same light constants.
- One natural sub-module, sensor_debounce: the synchroniser plus debounce counter, with parameter DEBOUNCE_CYCLES. It outputs det and a one-cycle det_rise used for car_count.

Test Plan:
- Reset then a clean step: sensor_raw 0->1 held, light_farm=100 -> det rises on edge 6 and c on edge 7; car_count=1; c stays 1 while light_farm stays red.
- Glitch rejection: sensor_raw high for 3 cycles, then low -> det, c and car_count stay 0.
- Min green: request granted, light_farm=001 at cycle T, sensor already released -> c falls after exactly 8 cycles of green; light_farm=100 -> state IDLE.
- Max green: sensor held high, light_farm=001 from T -> c falls after 32 green cycles, with timeout_pulse=1 for that single cycle. Once red returns with the sensor still high, c re-asserts one edge later.
- Early exit and reset: controller drops to 010 after 3 green cycles -> c=0 next edge with no timeout_pulse. In a separate run, rst_n=0 during SERVE -> c=0 and car_count=0 on that edge.
- Saturation: with CNT_W=2, 5 debounced arrivals -> car_count=3.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the farm/highway traffic light slice.
//   RED/YELLOW/GREEN : one-hot farm lamp encodings, also used by the controller
//   IDLE..RELEASE    : request conditioner state encodings
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQUEST = 2'd1;
  localparam logic [1:0] SERVE   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for the loop detector.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   sensor_raw : asynchronous detector level
//   det        : debounced level (registered)
//   det_rise   : high in the cycle whose closing edge takes det from 0 to 1
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  output logic det,
  output logic det_rise
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_q1;
  logic          s_sync;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          det_q, det_d;

  always_comb begin
    cnt_d = '0;
    det_d = det_q;
    if (s_sync != det_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        det_d = ~det_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // Combinational so the arrival counter updates on the same edge as det.
  assign det_rise = det_d & ~det_q;
  assign det      = det_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      s_sync  <= 1'b0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
    end else begin
      sync_q1 <= sensor_raw;
      s_sync  <= sync_q1;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
    end
  end

endmodule

// File: rtl/farm_request_conditioner.sv
// Conditions the farm-road detector into the controller's car-present input c.
// Latches a request, holds it through a farm green window bounded by MIN_GREEN
// and MAX_GREEN, and cuts it at MAX_GREEN so the highway is never starved.
//   clk           : system clock
//   rst_n         : synchronous active-low reset
//   sensor_raw    : asynchronous loop-detector level
//   light_farm    : controller farm lamp feedback (one-hot)
//   c             : registered service request
//   det           : debounced vehicle-present level
//   car_count     : saturating count of debounced arrivals
//   timeout_pulse : one-cycle pulse when a green is cut by MAX_GREEN
module farm_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_GREEN       = 8,
  parameter int unsigned MAX_GREEN       = 32,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic [2:0]       light_farm,
  output logic             c,
  output logic             det,
  output logic [CNT_W-1:0] car_count,
  output logic             timeout_pulse
);

  import traffic_pkg::*;

  localparam int unsigned GW = $clog2(MAX_GREEN) + 1;

  logic             det_rise;
  logic             green;
  logic             red;
  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    green_cnt_q, green_cnt_d;
  logic             c_q, c_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] car_count_q;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_raw(sensor_raw),
    .det       (det),
    .det_rise  (det_rise)
  );

  // Illegal lamp codes decode as neither green nor red.
  assign green = (light_farm == GREEN);
  assign red   = (light_farm == RED);

  always_comb begin
    state_d     = state_q;
    green_cnt_d = green_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (det) state_d = REQUEST;
      end
      REQUEST: begin
        // Latched: det dropping here does not withdraw the request.
        if (green) begin
          state_d     = SERVE;
          green_cnt_d = '0;
        end
      end
      SERVE: begin
        // Stops at MAX_GREEN at most, which fits GW bits, so never wraps.
        green_cnt_d = green_cnt_q + GW'(1);
        if (!green) begin
          state_d = RELEASE;
        end else if (green_cnt_q == GW'(MAX_GREEN - 1)) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else if ((green_cnt_q >= GW'(MIN_GREEN - 1)) && !det) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (red) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign c_d = (state_d == REQUEST) || (state_d == SERVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      green_cnt_q <= '0;
      c_q         <= 1'b0;
      timeout_q   <= 1'b0;
      car_count_q <= '0;
    end else begin
      state_q     <= state_d;
      green_cnt_q <= green_cnt_d;
      c_q         <= c_d;
      timeout_q   <= timeout_d;
      if (det_rise && (car_count_q != {CNT_W{1'b1}})) begin
        car_count_q <= car_count_q + CNT_W'(1);
      end
    end
  end

  assign c             = c_q;
  assign timeout_pulse = timeout_q;
  assign car_count     = car_count_q;

endmodule

// File: tb/tb_farm_request_conditioner.sv
// Randomised self-checking bench for farm_request_conditioner. A second
// instance with a 2-bit arrival counter shares the stimulus to cover saturation.
module tb_farm_request_conditioner;
  import traffic_pkg::*;

  localparam int DEB   = 4;
  localparam int MING  = 8;
  localparam int MAXG  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_raw;
  logic [2:0] light_farm;

  logic       c, det, timeout_pulse;
  logic [7:0] car_count;
  logic       c_s, det_s, timeout_s;
  logic [1:0] car_count_s;

  always #5 clk = ~clk;

  farm_request_conditioner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_raw   (sensor_raw),
    .light_farm   (light_farm),
    .c            (c),
    .det          (det),
    .car_count    (car_count),
    .timeout_pulse(timeout_pulse)
  );

  farm_request_conditioner #(
    .CNT_W(2)
  ) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_raw   (sensor_raw),
    .light_farm   (light_farm),
    .c            (c_s),
    .det          (det_s),
    .car_count    (car_count_s),
    .timeout_pulse(timeout_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sensor history, run length of disagreement, and a
  // description of the request lifecycle in terms of served green cycles.
  bit m_s1, m_sync, m_det;
  int m_run;
  int m_arrivals;
  bit m_pending;    // request latched, waiting for green
  bit m_serving;    // inside a green window
  bit m_wait_red;   // window over, waiting for red before a new request
  int m_served;     // green cycles already spent in the current window
  bit m_to;
  int n_timeouts;

  function automatic bit m_c();
    return m_pending || m_serving;
  endfunction

  task automatic model_edge();
    bit old_sync, old_det, g, r;
    int served_now;
    if (!rst_n) begin
      m_s1 = 0; m_sync = 0; m_det = 0; m_run = 0; m_arrivals = 0;
      m_pending = 0; m_serving = 0; m_wait_red = 0; m_served = 0; m_to = 0;
      return;
    end
    old_sync = m_sync;
    old_det  = m_det;
    g = (light_farm == GREEN);
    r = (light_farm == RED);
    m_sync = m_s1;
    m_s1   = sensor_raw;
    // det follows the synchronised level after DEB consecutive disagreeing cycles
    if (old_sync != old_det) begin
      m_run++;
      if (m_run == DEB) begin
        m_det = old_sync;
        m_run = 0;
        if (m_det) m_arrivals++;
      end
    end else begin
      m_run = 0;
    end
    m_to = 0;
    if (m_serving) begin
      served_now = m_served + 1;
      m_served   = served_now;
      if (!g || served_now == MAXG || (served_now >= MING && !old_det)) begin
        m_serving  = 0;
        m_wait_red = 1;
        m_to       = g && (served_now == MAXG);
        if (m_to) n_timeouts++;
      end
    end else if (m_pending) begin
      if (g) begin
        m_pending = 0;
        m_serving = 1;
        m_served  = 0;
      end
    end else if (m_wait_red) begin
      if (r) m_wait_red = 0;
    end else if (old_det) begin
      m_pending = 1;
    end
  endtask

  task automatic step(input logic s, input logic [2:0] l, input logic rn);
    int exp_sat;
    sensor_raw = s;
    light_farm = l;
    rst_n      = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_sat = (m_arrivals > 3) ? 3 : m_arrivals;
    check("c", c, m_c());
    check("det", det, m_det);
    check("car_count", car_count, (m_arrivals > 255) ? 255 : m_arrivals);
    check("timeout_pulse", timeout_pulse, m_to);
    check("c_sat", c_s, m_c());
    check("det_sat", det_s, m_det);
    check("car_count_sat", car_count_s, exp_sat);
    check("timeout_sat", timeout_s, m_to);
  endtask

  initial begin
    logic       lvl;
    int         seg_left;
    logic [2:0] lamp;
    logic       rn;
    bit         did_serve_reset;

    sensor_raw = 1'b0;
    light_farm = RED;
    rst_n      = 1'b0;
    n_timeouts = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b0, RED, 1'b0);
    // Clean step under red: det on edge 6, c on edge 7, c held while red.
    for (int i = 0; i < 14; i++) step(1'b1, RED, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, RED, 1'b1);
    // Grant then illegal / yellow lamp ends the window early.
    for (int i = 0; i < 3; i++) step(1'b0, GREEN, 1'b1);
    step(1'b0, YELLOW, 1'b1);
    step(1'b0, YELLOW, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, RED, 1'b1);
    // Glitch of three cycles must not reach det.
    for (int i = 0; i < 3; i++) step(1'b1, RED, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, RED, 1'b1);

    lvl = 1'b0;
    seg_left = 0;
    lamp = RED;
    did_serve_reset = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (seg_left == 0) begin
        lvl = ~lvl;
        seg_left = ($urandom % 10 < 3) ? int'($urandom_range(1, 3))
                                       : int'($urandom_range(4, 80));
      end
      seg_left--;
      // Crude controller: grants green to a request, leaves green when c drops.
      if (lamp == GREEN) begin
        if (!m_c() || ($urandom % 64 == 0)) lamp = YELLOW;
      end else if (lamp == YELLOW) begin
        if ($urandom % 3 != 0) lamp = RED;
      end else if (m_c() && ($urandom % 4 == 0)) begin
        lamp = GREEN;
      end else if ($urandom % 32 == 0) begin
        lamp = 3'($urandom);
      end else begin
        lamp = RED;
      end
      rn = ($urandom % 700 != 0);
      if (!did_serve_reset && m_serving && m_served == 5) begin
        rn = 1'b0;
        did_serve_reset = 1;
      end
      step(lvl, lamp, rn);
    end

    check("timeouts_seen", (n_timeouts > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
